// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver (8 data bits, LSB first)
//
// Purpose:
//   Recovers bytes from an asynchronous serial line. The line is brought into
//   the clock domain through a two-flop synchronizer. Each bit is timed by a
//   counter running 0..OVERSAMPLE-1 and decided by a 3-sample majority vote
//   around the bit centre. Good bytes are presented on p_data with a one-cycle
//   data_valid pulse. Framing and parity faults are reported as one-cycle
//   error pulses instead.
//
// Optional feature:
//   Define UART_RX_PARITY_EN to add the par_en / par_typ inputs, the par_err
//   output and the PARITY state. Without it a frame is start + 8 data + stop.
//
// Parameters:
//   OVERSAMPLE  clock cycles per bit (8, 16 or 32)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx_in       serial line, idle high, asynchronous to clk
//   par_en      (UART_RX_PARITY_EN) frame carries a parity bit
//   par_typ     (UART_RX_PARITY_EN) 0 = even parity, 1 = odd parity
//   p_data      last correctly received byte
//   data_valid  one-cycle pulse, p_data has just been updated
//   par_err     (UART_RX_PARITY_EN) one-cycle pulse, parity mismatch
//   stp_err     one-cycle pulse, stop bit sampled low
//   busy        high whenever a frame is being received
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
`ifdef UART_RX_PARITY_EN
  input  logic       par_en,
  input  logic       par_typ,
`endif
  output logic [7:0] p_data,
  output logic       data_valid,
`ifdef UART_RX_PARITY_EN
  output logic       par_err,
`endif
  output logic       stp_err,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] SAMP_A   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SAMP_B   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] DECIDE   = CW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic            rxMeta_q, rxMeta_d;
  logic            rxSync_q, rxSync_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      pData_q, pData_d;
  logic            dataValid_q, dataValid_d;
  logic            stpErr_q, stpErr_d;
  logic            armed_q, armed_d;
  logic            bitVal;
`ifdef UART_RX_PARITY_EN
  logic            parEn_q, parEn_d;
  logic            parTyp_q, parTyp_d;
  logic            parBad_q, parBad_d;
  logic            parErr_q, parErr_d;
`endif

  // Majority of the two stored centre samples and the live third sample.
  // Only meaningful on the decision count, which is the only place it is used.
  assign bitVal = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxSync_q) |
                  (samp_q[1] & rxSync_q);

  // State register. Reset puts the synchronizer flops at the idle line level
  // so that a reset never looks like the leading edge of a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      rxMeta_q    <= 1'b1;
      rxSync_q    <= 1'b1;
      samp_q      <= '0;
      shift_q     <= '0;
      pData_q     <= 8'h00;
      dataValid_q <= 1'b0;
      stpErr_q    <= 1'b0;
      armed_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
      parEn_q     <= 1'b0;
      parTyp_q    <= 1'b0;
      parBad_q    <= 1'b0;
      parErr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitIdx_q    <= bitIdx_d;
      rxMeta_q    <= rxMeta_d;
      rxSync_q    <= rxSync_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      pData_q     <= pData_d;
      dataValid_q <= dataValid_d;
      stpErr_q    <= stpErr_d;
      armed_q     <= armed_d;
`ifdef UART_RX_PARITY_EN
      parEn_q     <= parEn_d;
      parTyp_q    <= parTyp_d;
      parBad_q    <= parBad_d;
      parErr_q    <= parErr_d;
`endif
    end
  end

  // Next-state logic. The bit counter free-runs while a frame is active and
  // every bit is decided on count OVERSAMPLE/2+1. The stop bit releases the
  // FSM right after its decision, half a bit early, so a following start
  // edge is never missed. armed_q blocks a new start after a stop error
  // until the line has been seen high again, so a stuck-low line cannot
  // produce a stream of bogus frames.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitIdx_d    = bitIdx_q;
    rxMeta_d    = rx_in;
    rxSync_d    = rxMeta_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    pData_d     = pData_q;
    dataValid_d = 1'b0;
    stpErr_d    = 1'b0;
    armed_d     = armed_q | rxSync_q;
`ifdef UART_RX_PARITY_EN
    parEn_d     = parEn_q;
    parTyp_d    = parTyp_q;
    parBad_d    = parBad_q;
    parErr_d    = 1'b0;
`endif

    if (state_q != IDLE) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == SAMP_A) samp_d[0] = rxSync_q;
      if (cnt_q == SAMP_B) samp_d[1] = rxSync_q;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxSync_q && armed_q) begin
          state_d  = START;
`ifdef UART_RX_PARITY_EN
          parEn_d  = par_en;
          parTyp_d = par_typ;
          parBad_d = 1'b0;
`endif
        end
      end

      START: begin
        if (cnt_q == DECIDE && bitVal) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DATA;
          bitIdx_d = '0;
        end
      end

      DATA: begin
        if (cnt_q == DECIDE) shift_d = {bitVal, shift_q[7:1]};
        if (cnt_q == CNT_LAST) begin
          if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = parEn_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == DECIDE) parBad_d = (bitVal != ((^shift_q) ^ parTyp_q));
        if (cnt_q == CNT_LAST) state_d = STOP;
      end
`endif

      STOP: begin
        if (cnt_q == DECIDE) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!bitVal) armed_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          if (bitVal && !parBad_q) begin
            dataValid_d = 1'b1;
            pData_d     = shift_q;
          end
          stpErr_d = !bitVal;
          parErr_d = parBad_q;
`else
          if (bitVal) begin
            dataValid_d = 1'b1;
            pData_d     = shift_q;
          end
          stpErr_d = !bitVal;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign p_data     = pData_q;
  assign data_valid = dataValid_q;
  assign stp_err    = stpErr_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign par_err    = parErr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- scoreboard bench for uart_rx
//
// Two receivers share the clock: dutA at OVERSAMPLE=8 and dutB at
// OVERSAMPLE=16, each with its own serial line. applyStimulus serialises a
// frame and pushes the expected outcome, worked out from the frame rules,
// into that receiver's queue. A monitor per receiver pops the queue whenever
// a data_valid / stp_err / par_err pulse appears and compares it.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS_A = 8;
  localparam int OS_B = 16;

  typedef struct {
    logic [7:0] pData;
    bit         valid;
    bit         parErr;
    bit         stpErr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxA, rxB;
  logic [7:0] pDataA, pDataB;
  logic       dvA, dvB, seA, seB, busyA, busyB;
  logic       peA, peB;
`ifdef UART_RX_PARITY_EN
  logic       parEnA, parTypA, parEnB, parTypB;
`endif

  exp_t       qA[$];
  exp_t       qB[$];
  logic [7:0] lastGoodA, lastGoodB;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_rx #(.OVERSAMPLE(OS_A)) dutA (
    .clk(clk), .rst(rst), .rx_in(rxA),
`ifdef UART_RX_PARITY_EN
    .par_en(parEnA), .par_typ(parTypA), .par_err(peA),
`endif
    .p_data(pDataA), .data_valid(dvA), .stp_err(seA), .busy(busyA)
  );

  uart_rx #(.OVERSAMPLE(OS_B)) dutB (
    .clk(clk), .rst(rst), .rx_in(rxB),
`ifdef UART_RX_PARITY_EN
    .par_en(parEnB), .par_typ(parTypB), .par_err(peB),
`endif
    .p_data(pDataB), .data_valid(dvB), .stp_err(seB), .busy(busyB)
  );

`ifndef UART_RX_PARITY_EN
  assign peA = 1'b0;
  assign peB = 1'b0;
`endif

  // Single comparison: bumps the counters and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One monitor step for receiver d: any output pulse consumes one expectation.
  task automatic monitorStep(input int d, input logic dv, input logic se,
                             input logic pe, input logic [7:0] pd);
    exp_t e;
    int   sz;
    sz = (d == 0) ? qA.size() : qB.size();
    if (dv || se || pe) begin
      if (sz == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedPulse%0d: got dv=%b stp=%b par=%b, expected no pulse",
                 d, dv, se, pe);
      end else begin
        e = (d == 0) ? qA.pop_front() : qB.pop_front();
        checkOutput($sformatf("dataValid%0d", d), {31'd0, dv}, {31'd0, e.valid});
        checkOutput($sformatf("stpErr%0d", d), {31'd0, se}, {31'd0, e.stpErr});
        checkOutput($sformatf("parErr%0d", d), {31'd0, pe}, {31'd0, e.parErr});
        checkOutput($sformatf("pData%0d", d), {24'd0, pd}, {24'd0, e.pData});
      end
    end
  endtask

  // Monitors sample on the falling edge, away from the DUT's register updates.
  always @(negedge clk) if (!rst) monitorStep(0, dvA, seA, peA, pDataA);
  always @(negedge clk) if (!rst) monitorStep(1, dvB, seB, peB, pDataB);

  // Hold one line level for one bit time on receiver d.
  task automatic driveBit(input int d, input logic v);
    if (d == 0) begin
      rxA = v;
      repeat (OS_A) @(negedge clk);
    end else begin
      rxB = v;
      repeat (OS_B) @(negedge clk);
    end
  endtask

  // Serialise one frame and queue its expected outcome. The reference rule:
  // a correct parity bit makes the total count of ones even (typ=0) or odd
  // (typ=1); flipPar sends the opposite bit. A byte is delivered only with a
  // high stop bit and no parity fault; otherwise p_data keeps the last good byte.
  task automatic applyStimulus(input int d, input logic [7:0] data, input bit usePar,
                               input bit typ, input bit flipPar, input bit stopBit);
    exp_t e;
    bit   parBit;
    parBit   = bit'($countones(data) % 2) ^ typ ^ flipPar;
    e.parErr = usePar && flipPar;
    e.stpErr = !stopBit;
    e.valid  = stopBit && !e.parErr;
    if (d == 0) begin
      if (e.valid) lastGoodA = data;
      e.pData = lastGoodA;
      qA.push_back(e);
    end else begin
      if (e.valid) lastGoodB = data;
      e.pData = lastGoodB;
      qB.push_back(e);
    end
`ifdef UART_RX_PARITY_EN
    if (d == 0) begin parEnA = usePar; parTypA = typ; end
    else        begin parEnB = usePar; parTypB = typ; end
`endif
    driveBit(d, 1'b0);
    checkOutput($sformatf("busyInFrame%0d", d), {31'd0, (d == 0) ? busyA : busyB}, 32'd1);
`ifdef UART_RX_PARITY_EN
    // Mid-frame changes to the parity config must be ignored.
    if (d == 0) begin parEnA = !usePar; parTypA = !typ; end
`endif
    for (int i = 0; i < 8; i++) driveBit(d, data[i]);
    if (usePar) driveBit(d, parBit);
    driveBit(d, stopBit);
    if (!stopBit) begin
      // Line stays low after a framing error: receiver must not restart.
      driveBit(d, 1'b0);
      checkOutput($sformatf("noRestartLowLine%0d", d),
                  {31'd0, (d == 0) ? busyA : busyB}, 32'd0);
      driveBit(d, 1'b1);
    end
  endtask

  initial begin
    bit   usePar, typ, flip, stopBit;
    int   waited;
    rst = 1'b1;
    rxA = 1'b1;
    rxB = 1'b1;
    lastGoodA = 8'h00;
    lastGoodB = 8'h00;
`ifdef UART_RX_PARITY_EN
    parEnA = 1'b0; parTypA = 1'b0; parEnB = 1'b0; parTypB = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("resetPData", {24'd0, pDataA}, 32'h0);
    checkOutput("resetValid", {31'd0, dvA}, 32'd0);
    checkOutput("resetStpErr", {31'd0, seA}, 32'd0);
    checkOutput("resetBusyA", {31'd0, busyA}, 32'd0);
    checkOutput("resetBusyB", {31'd0, busyB}, 32'd0);

    $display("[TB] basic frame 0xA5");
    applyStimulus(0, 8'hA5, 0, 0, 0, 1);
    repeat (2 * OS_A) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity frames 0x3C");
    applyStimulus(0, 8'h3C, 1, 0, 0, 1);
    repeat (OS_A) @(negedge clk);
    applyStimulus(0, 8'h3C, 1, 0, 1, 1);
    repeat (OS_A) @(negedge clk);
    applyStimulus(0, 8'h96, 1, 1, 0, 1);
    repeat (OS_A) @(negedge clk);
    applyStimulus(0, 8'h96, 1, 1, 1, 0);
    repeat (2 * OS_A) @(negedge clk);
`endif

    $display("[TB] stop error 0x55");
    applyStimulus(0, 8'h55, 0, 0, 0, 0);
    repeat (OS_A) @(negedge clk);

    $display("[TB] idle glitch then 0x81");
    rxA = 1'b0;
    repeat (2) @(negedge clk);
    rxA = 1'b1;
    repeat (2 * OS_A) @(negedge clk);
    checkOutput("glitchBackToIdle", {31'd0, busyA}, 32'd0);
    applyStimulus(0, 8'h81, 0, 0, 0, 1);
    repeat (2 * OS_A) @(negedge clk);

    $display("[TB] reset in the middle of 0xFF");
    driveBit(0, 1'b0);
    for (int i = 0; i < 4; i++) driveBit(0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midResetPData", {24'd0, pDataA}, 32'h0);
    checkOutput("midResetValid", {31'd0, dvA}, 32'd0);
    checkOutput("midResetStpErr", {31'd0, seA}, 32'd0);
    checkOutput("midResetParErr", {31'd0, peA}, 32'd0);
    checkOutput("midResetBusy", {31'd0, busyA}, 32'd0);
    rst = 1'b0;
    lastGoodA = 8'h00;
    lastGoodB = 8'h00;
    repeat (6 * OS_A) @(negedge clk);
    checkOutput("afterResetQuiet", {31'd0, busyA}, 32'd0);
    applyStimulus(0, 8'h12, 0, 0, 0, 1);

    $display("[TB] random frames on OVERSAMPLE=8");
    for (int n = 0; n < 24; n++) begin
      stopBit = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      usePar = 1'($urandom_range(0, 1));
      typ    = 1'($urandom_range(0, 1));
      flip   = ($urandom_range(0, 3) == 0);
`else
      usePar = 1'b0;
      typ    = 1'b0;
      flip   = 1'b0;
`endif
      applyStimulus(0, 8'($urandom), usePar, typ, flip, stopBit);
      repeat ($urandom_range(0, OS_A)) @(negedge clk);
    end

    $display("[TB] back-to-back frames on OVERSAMPLE=16");
    applyStimulus(1, 8'h01, 0, 0, 0, 1);
    applyStimulus(1, 8'hFE, 0, 0, 0, 1);
    for (int n = 0; n < 6; n++) applyStimulus(1, 8'($urandom), 0, 0, 0, 1);

    waited = 0;
    while ((qA.size() != 0 || qB.size() != 0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    checkOutput("drainQueueA", qA.size(), 32'd0);
    checkOutput("drainQueueB", qB.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
